// File: rtl/palette_arbiter.sv
// Round-robin arbiter sharing one registered palette lookup between the start and final screens.
// Optional feature: define PALETTE_ROTATE_EN to rotate the final palette by one entry per frame_tick.
module palette_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [3:0]  s_index,
  output logic        s_ready,
  input  logic        f_valid,
  input  logic [1:0]  f_index,
  output logic        f_ready,
  input  logic        frame_tick,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] rgb,
  output logic        out_src
);

  logic        last_src;
  logic        s1_valid;
  logic        s1_src;
  logic [3:0]  s1_index;
  logic        s2_valid;
  logic        s2_src;
  logic [11:0] s2_rgb;

  logic        grant_s;
  logic        grant_f;
  logic        s2_free;
  logic        s1_free;
  logic        s1_adv;
  logic        s_acc;
  logic        f_acc;
  logic [1:0]  final_index;
  logic [11:0] decoded;

  // When both requesters are valid, the one that did not win last time gets the slot.
  always_comb begin
    grant_s = s_valid & (~f_valid | last_src);
    grant_f = f_valid & (~s_valid | ~last_src);
    s2_free = ~s2_valid | out_ready;
    s1_adv  = s1_valid & s2_free;
    s1_free = ~s1_valid | s2_free;
    s_ready = rst_n & grant_s & s1_free;
    f_ready = rst_n & grant_f & s1_free;
    s_acc   = s_valid & s_ready;
    f_acc   = f_valid & f_ready;
  end

`ifdef PALETTE_ROTATE_EN
  logic [1:0] rot_offset;

  always_ff @(posedge clk) begin
    if (!rst_n)
      rot_offset <= 2'd0;
    else if (frame_tick)
      rot_offset <= rot_offset + 2'd1;
  end

  assign final_index = s1_index[1:0] + rot_offset;
`else
  logic unused_tick;

  assign unused_tick = frame_tick;
  assign final_index = s1_index[1:0];
`endif

  always_comb begin
    decoded = 12'hF0F;
    if (s1_src) begin
      case (final_index)
        2'd0:    decoded = 12'hFE0;
        2'd1:    decoded = 12'h799;
        2'd2:    decoded = 12'hFFF;
        default: decoded = 12'hBE9;
      endcase
    end else begin
      case (s1_index)
        4'd0:    decoded = 12'hBEB;
        4'd1:    decoded = 12'hDD0;
        4'd2:    decoded = 12'hFFF;
        4'd3:    decoded = 12'hC54;
        4'd4:    decoded = 12'h7BA;
        4'd5:    decoded = 12'h6CB;
        4'd6:    decoded = 12'h435;
        4'd7:    decoded = 12'hAC5;
        default: decoded = 12'hF0F;
      endcase
    end
  end

  // Stage 1 may refill in the same cycle it hands its entry to stage 2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_src <= 1'b1;
      s1_valid <= 1'b0;
      s1_src   <= 1'b0;
      s1_index <= 4'd0;
      s2_valid <= 1'b0;
      s2_src   <= 1'b0;
      s2_rgb   <= 12'h000;
    end else begin
      if (s_acc | f_acc) begin
        last_src <= f_acc;
        s1_valid <= 1'b1;
        s1_src   <= f_acc;
        s1_index <= f_acc ? {2'b00, f_index} : s_index;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_src   <= s1_src;
        s2_rgb   <= decoded;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign rgb       = s2_rgb;
  assign out_src   = s2_src;

endmodule

// File: tb/tb_palette_arbiter.sv
// Self-checking bench for palette_arbiter: directed scenarios plus randomized traffic against a queue model.
// Honors PALETTE_ROTATE_EN the same way the design does.
module tb_palette_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [3:0]  s_index;
  logic        s_ready;
  logic        f_valid;
  logic [1:0]  f_index;
  logic        f_ready;
  logic        frame_tick;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] rgb;
  logic        out_src;

  palette_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_index    (s_index),
    .s_ready    (s_ready),
    .f_valid    (f_valid),
    .f_index    (f_index),
    .f_ready    (f_ready),
    .frame_tick (frame_tick),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rgb        (rgb),
    .out_src    (out_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] colour;
    logic        src;
    int          acc_cycle;
  } entry_t;

  entry_t q[$];
  int     cycle      = 0;
  logic   model_last = 1'b1;
  int     model_off  = 0;
  int     checks     = 0;
  int     failures   = 0;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  function automatic logic [11:0] startColour(input int idx);
    logic [11:0] table_s [8] = '{12'hBEB, 12'hDD0, 12'hFFF, 12'hC54,
                                 12'h7BA, 12'h6CB, 12'h435, 12'hAC5};
    if (idx >= 8) return 12'hF0F;
    return table_s[idx];
  endfunction

  function automatic logic [11:0] finalColour(input int idx);
    logic [11:0] table_f [4] = '{12'hFE0, 12'h799, 12'hFFF, 12'hBE9};
    return table_f[idx % 4];
  endfunction

  // One clock cycle: drive inputs, compare against the model mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input logic rst, input logic sv, input logic [3:0] si,
                               input logic fv, input logic [1:0] fi,
                               input logic ordy, input logic tick);
    logic   exp_ov;
    logic   exp_pop;
    logic   can_acc;
    logic   exp_sr;
    logic   exp_fr;
    int     gsrc;
    entry_t e;
    @(negedge clk);
    rst_n      = rst;
    s_valid    = sv;
    s_index    = si;
    f_valid    = fv;
    f_index    = fi;
    out_ready  = ordy;
    frame_tick = tick;
    #1;
    exp_ov  = (q.size() > 0) && (cycle >= q[0].acc_cycle + 2);
    exp_pop = exp_ov && ordy;
    can_acc = (q.size() < 2) || exp_pop;
    gsrc = -1;
    if (sv && fv)  gsrc = model_last ? 0 : 1;
    else if (sv)   gsrc = 0;
    else if (fv)   gsrc = 1;
    exp_sr = rst && (gsrc == 0) && can_acc;
    exp_fr = rst && (gsrc == 1) && can_acc;
    checkOutput("out_valid", 16'(out_valid), 16'(exp_ov));
    checkOutput("s_ready", 16'(s_ready), 16'(exp_sr));
    checkOutput("f_ready", 16'(f_ready), 16'(exp_fr));
    if (exp_ov) begin
      checkOutput("rgb", 16'(rgb), 16'(q[0].colour));
      checkOutput("out_src", 16'(out_src), 16'(q[0].src));
    end
    @(posedge clk);
    if (!rst) begin
      q.delete();
      model_last = 1'b1;
      model_off  = 0;
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_sr || exp_fr) begin
        e.src       = exp_fr;
        e.colour    = exp_fr ? finalColour(int'(fi) + model_off) : startColour(int'(si));
        e.acc_cycle = cycle;
        q.push_back(e);
        model_last = exp_fr;
      end
`ifdef PALETTE_ROTATE_EN
      if (tick) model_off = (model_off + 1) % 4;
`endif
    end
    cycle++;
  endtask

  initial begin
    rst_n      = 1'b0;
    s_valid    = 1'b0;
    s_index    = 4'd0;
    f_valid    = 1'b0;
    f_index    = 2'd0;
    out_ready  = 1'b0;
    frame_tick = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 1, 3, 1, 1, 1, 0);
    #1;
    checkOutput("reset_out_valid", 16'(out_valid), 16'h0);
    checkOutput("reset_rgb", 16'(rgb), 16'h000);

    // Single start request, index 3.
    applyStimulus(1, 1, 3, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    #1;
    checkOutput("single_valid", 16'(out_valid), 16'h1);
    checkOutput("single_rgb", 16'(rgb), 16'hC54);
    checkOutput("single_src", 16'(out_src), 16'h0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    #1;
    checkOutput("single_drain", 16'(out_valid), 16'h0);

    // Both always valid: strict alternation starting with start-screen.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 1, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);

    // Error-magenta index.
    applyStimulus(1, 1, 9, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    #1;
    checkOutput("magenta_rgb", 16'(rgb), 16'hF0F);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);

    // Stall with out_ready low, then release.
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 2, 1, 3, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 1, 0);

    // Reset with two entries in flight.
    applyStimulus(1, 1, 5, 1, 0, 0, 0);
    applyStimulus(1, 1, 5, 1, 0, 0, 0);
    applyStimulus(0, 1, 5, 1, 0, 0, 0);
    #1;
    checkOutput("midreset_valid", 16'(out_valid), 16'h0);
    checkOutput("midreset_rgb", 16'(rgb), 16'h000);
    checkOutput("midreset_src", 16'(out_src), 16'h0);
    applyStimulus(1, 1, 5, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 0);

    // Palette rotation by two frames, final index 3.
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 3, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    #1;
`ifdef PALETTE_ROTATE_EN
    checkOutput("rotate_rgb", 16'(rgb), 16'h799);
`else
    checkOutput("rotate_rgb", 16'(rgb), 16'hBE9);
`endif
    applyStimulus(1, 0, 0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                    ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                    4'($urandom_range(0, 15)),
                    ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                    1'b0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
